// File: rtl/vin_pkg.sv
// vin_pkg: shared state encoding, widths and helpers for the video-input
// frame-lock logic (vin_frame_sync and its sub-blocks).
package vin_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_ACQUIRE  = 2'd1,
    ST_LOCKED   = 2'd2
  } vfs_state_e;

  // Width of the lock-loss counter.
  localparam int ERR_CNT_W  = 8;
  // Width of the consecutive-good-frame counter (LOCK_FRAMES is at most 15).
  localparam int GOOD_CNT_W = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == '1) ? v : v + ERR_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vfs_edge_det.sv
// vfs_edge_det: registered single-edge detector. o_dly is the input delayed
// one cycle; o_edge is combinational from the input and that registered copy,
// so it is high during the first cycle after the selected transition.
module vfs_edge_det #(
  parameter bit RISING = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_dly,
  output logic o_edge
);

  logic r_sig;

  // Registered copy of the input used as the edge reference.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sig <= 1'b0;
    else     r_sig <= i_sig;
  end

  assign o_dly  = r_sig;
  assign o_edge = RISING ? (i_sig & ~r_sig) : (~i_sig & r_sig);

endmodule

// File: rtl/vin_frame_sync.sv
// vin_frame_sync: frame-lock and geometry checker in the pixel-clock domain.
// Counts pixels per line and lines per frame, locks after LOCK_FRAMES clean
// frames, gates o_de while unlocked and drops lock on any geometry error.
// There is no backpressure: the stream is pass-through with 1-cycle latency.
// Optional: define VIN_FRAME_SYNC_STATS_EN to add the meas_h/meas_v outputs.
// o_state exposes the lock FSM state for debug.
module vin_frame_sync
  import vin_pkg::*;
#(
  parameter int H_ACT       = 800,
  parameter int V_ACT       = 1200,
  parameter int LOCK_FRAMES = 2,
  parameter int CNT_W       = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_vsync,
  input  logic                 i_hsync,
  input  logic                 i_de,
  input  logic [7:0]           i_pixel,
  output logic                 o_vsync,
  output logic                 o_hsync,
  output logic                 o_de,
  output logic [7:0]           o_pixel,
  output logic                 o_frame_start,
  output logic                 locked,
  output logic                 err_h,
  output logic                 err_v,
  output logic [ERR_CNT_W-1:0] err_count,
`ifdef VIN_FRAME_SYNC_STATS_EN
  output logic [CNT_W-1:0]     meas_h,
  output logic [CNT_W-1:0]     meas_v,
`endif
  output vfs_state_e           o_state
);

  localparam logic [CNT_W-1:0]      H_ACT_C = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0]      V_ACT_C = CNT_W'(V_ACT);
  localparam logic [GOOD_CNT_W-1:0] LOCK_C  = GOOD_CNT_W'(LOCK_FRAMES);

  vfs_state_e            r_state, w_state_nxt;
  logic [GOOD_CNT_W-1:0] r_good_cnt, w_good_nxt, w_good_inc;
  logic                  r_frame_bad, w_bad_nxt, w_lock_lost;
  logic [CNT_W-1:0]      r_h_cnt, r_v_cnt, w_v_eff;
  logic                  r_line_over;
  logic                  w_vs_rise, w_de_fall, w_vs_d, w_de_d;
  logic                  w_h_full, w_err_long, w_err_short, w_line_err, w_frame_err;
  logic [7:0]            r_pixel;
  logic                  r_hsync, r_err_h, r_err_v, r_frame_start;
  logic [ERR_CNT_W-1:0]  r_err_count;

  vfs_edge_det #(.RISING(1'b1)) u_vs_det (
    .clk(clk), .rst(rst), .i_sig(i_vsync), .o_dly(w_vs_d), .o_edge(w_vs_rise)
  );

  vfs_edge_det #(.RISING(1'b0)) u_de_det (
    .clk(clk), .rst(rst), .i_sig(i_de), .o_dly(w_de_d), .o_edge(w_de_fall)
  );

  // A line is short/long at de_fall, or overlong the moment pixel H_ACT+1
  // arrives; r_line_over stops the later de_fall from reporting it twice.
  assign w_h_full    = (r_h_cnt == H_ACT_C);
  assign w_err_long  = i_de & w_h_full;
  assign w_err_short = w_de_fall & ~w_h_full & ~r_line_over;
  assign w_line_err  = w_err_long | w_err_short;

  // Line count including a line that ends on this very cycle, so a de_fall
  // coincident with vs_rise is credited to the frame that is ending.
  assign w_v_eff     = (w_de_fall && (r_v_cnt != '1)) ? r_v_cnt + CNT_W'(1) : r_v_cnt;
  // The first frame edge after UNLOCKED closes a partial frame: never checked.
  assign w_frame_err = w_vs_rise & (r_state != ST_UNLOCKED) & (w_v_eff != V_ACT_C);
  assign w_good_inc  = r_good_cnt + GOOD_CNT_W'(1);

  // Lock FSM next-state and good-frame bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_frame_bad;
    w_lock_lost = 1'b0;
    case (r_state)
      ST_UNLOCKED: begin
        if (w_vs_rise) begin
          w_state_nxt = ST_ACQUIRE;
          w_good_nxt  = '0;
          w_bad_nxt   = 1'b0;
        end
      end
      ST_ACQUIRE: begin
        if (w_vs_rise) begin
          w_bad_nxt = 1'b0;
          if (w_frame_err || w_line_err || r_frame_bad) begin
            w_good_nxt = '0;
          end else begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == LOCK_C) w_state_nxt = ST_LOCKED;
          end
        end else if (w_line_err) begin
          w_good_nxt = '0;
          w_bad_nxt  = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (w_line_err || w_frame_err) begin
          w_state_nxt = ST_UNLOCKED;
          w_lock_lost = 1'b1;
        end
      end
      default: w_state_nxt = ST_UNLOCKED;
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_UNLOCKED;
      r_good_cnt  <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_good_cnt  <= w_good_nxt;
      r_frame_bad <= w_bad_nxt;
    end
  end

  // Pixel-per-line and line-per-frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt     <= '0;
      r_line_over <= 1'b0;
      r_v_cnt     <= '0;
    end else begin
      if (w_vs_rise || w_de_fall) begin
        r_h_cnt     <= '0;
        r_line_over <= 1'b0;
      end else begin
        if (i_de && (r_h_cnt != '1)) r_h_cnt <= r_h_cnt + CNT_W'(1);
        if (w_err_long) r_line_over <= 1'b1;
      end
      r_v_cnt <= w_vs_rise ? '0 : w_v_eff;
    end
  end

  // Registered stream copy, error pulses, frame-start pulse, lock-loss count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pixel       <= '0;
      r_hsync       <= 1'b0;
      r_err_h       <= 1'b0;
      r_err_v       <= 1'b0;
      r_frame_start <= 1'b0;
      r_err_count   <= '0;
    end else begin
      r_pixel       <= i_pixel;
      r_hsync       <= i_hsync;
      r_err_h       <= w_line_err;
      r_err_v       <= w_frame_err;
      r_frame_start <= w_vs_rise & (w_state_nxt == ST_LOCKED);
      if (w_lock_lost) r_err_count <= sat_inc(r_err_count);
    end
  end

`ifdef VIN_FRAME_SYNC_STATS_EN
  logic [CNT_W-1:0] r_meas_h, r_meas_v;

  // Last measured line length and frame height.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meas_h <= '0;
      r_meas_v <= '0;
    end else begin
      if (w_de_fall) r_meas_h <= r_h_cnt;
      if (w_vs_rise) r_meas_v <= w_v_eff;
    end
  end

  assign meas_h = r_meas_h;
  assign meas_v = r_meas_v;
`endif

  assign o_vsync       = w_vs_d;
  assign o_hsync       = r_hsync;
  assign o_pixel       = r_pixel;
  assign o_de          = w_de_d & (r_state == ST_LOCKED);
  assign o_frame_start = r_frame_start;
  assign locked        = (r_state == ST_LOCKED);
  assign err_h         = r_err_h;
  assign err_v         = r_err_v;
  assign err_count     = r_err_count;
  assign o_state       = r_state;

endmodule

// File: tb/tb_vin_frame_sync.sv
// tb_vin_frame_sync: directed bench for vin_frame_sync with a reduced
// geometry (6x3) so many frames fit in a short run. Passed pixels are pushed
// to exp_q when driven and popped when o_de shows them.
// Define VIN_FRAME_SYNC_STATS_EN to also exercise meas_h/meas_v.
module tb_vin_frame_sync;
  import vin_pkg::*;

  localparam int H  = 6;
  localparam int V  = 3;
  localparam int LF = 2;
  localparam int CW = 12;

  logic                 clk = 1'b0;
  logic                 rst, i_vsync, i_hsync, i_de;
  logic [7:0]           i_pixel;
  logic                 o_vsync, o_hsync, o_de, o_frame_start, locked, err_h, err_v;
  logic [7:0]           o_pixel;
  logic [ERR_CNT_W-1:0] err_count;
  vfs_state_e           o_state;
`ifdef VIN_FRAME_SYNC_STATS_EN
  logic [CW-1:0]        meas_h, meas_v;
`endif

  vin_frame_sync #(.H_ACT(H), .V_ACT(V), .LOCK_FRAMES(LF), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de),
    .i_pixel(i_pixel), .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de),
    .o_pixel(o_pixel), .o_frame_start(o_frame_start), .locked(locked),
    .err_h(err_h), .err_v(err_v), .err_count(err_count),
`ifdef VIN_FRAME_SYNC_STATS_EN
    .meas_h(meas_h), .meas_v(meas_v),
`endif
    .o_state(o_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard and bookkeeping
  logic [7:0] exp_q[$];
  logic [7:0] exp_pix;
  int checks = 0, errors = 0, cyc = 0;
  int n_err_h = 0, n_err_v = 0, n_fs = 0;
  int err_h_cyc = 0, err_v_cyc = 0, fs_cyc = 0, ode_rise_cyc = 0;
  int line_cyc = 0, over_cyc = 0, fall_cyc = 0, vs_cyc = 0;
  logic vs_prev = 1'b0, hs_prev = 1'b0, ode_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: outputs are sampled 1 time unit after the edge.
  task automatic tick();
    vs_prev = i_vsync;
    hs_prev = i_hsync;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) begin
      chk("o_vsync", o_vsync, vs_prev);
      chk("o_hsync", o_hsync, hs_prev);
      if (err_h === 1'b1) begin n_err_h++; err_h_cyc = cyc; end
      if (err_v === 1'b1) begin n_err_v++; err_v_cyc = cyc; end
      if (o_frame_start === 1'b1) begin n_fs++; fs_cyc = cyc; end
      if (o_de === 1'b1 && !ode_prev) ode_rise_cyc = cyc;
      ode_prev = o_de;
      if (o_de === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("o_de_spurious", o_de, 1'b0);
        end else begin
          exp_pix = exp_q.pop_front();
          chk("o_pixel", o_pixel, exp_pix);
        end
      end
    end
  endtask

  // Line of len pixels; the first npass are expected downstream.
  task automatic drive_line(input int len, input int npass, input int gap);
    for (int i = 0; i < len; i++) begin
      i_de    = 1'b1;
      i_pixel = 8'($urandom_range(0, 255));
      if (i == 0) line_cyc = cyc;
      if (i == H) over_cyc = cyc;
      if (i < npass) exp_q.push_back(i_pixel);
      tick();
    end
    i_de     = 1'b0;
    fall_cyc = cyc;
    for (int g = 0; g < gap; g++) begin
      i_hsync = (g == 0);
      tick();
    end
    i_hsync = 1'b0;
  endtask

  task automatic vsync_pulse();
    i_vsync = 1'b1;
    i_de    = 1'b0;
    vs_cyc  = cyc;
    tick();
    tick();
    i_vsync = 1'b0;
    tick();
    tick();
  endtask

  task automatic frame(input int nlines, input bit pass);
    for (int l = 0; l < nlines; l++) drive_line(H, pass ? H : 0, 2);
  endtask

  // Directed sequence
  initial begin
    rst = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_pixel = 8'd0;
    #2 rst = 1'b1;
    #1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_o_de", o_de, 1'b0);
    chk("rst_err_count", err_count, 0);
    chk("rst_err_h", err_h, 1'b0);
    chk("rst_err_v", err_v, 1'b0);
    chk("rst_frame_start", o_frame_start, 1'b0);
    chk("rst_o_vsync", o_vsync, 1'b0);
    chk("rst_o_pixel", o_pixel, 0);
    chk("rst_state", o_state, ST_UNLOCKED);
    tick(); tick();
    rst = 1'b0;
    tick(); tick();

    // Acquire: lock at the third frame edge
    vsync_pulse(); frame(V, 0);
    vsync_pulse(); chk("lock_vs2", locked, 1'b0); frame(V, 0);
    vsync_pulse();
    chk("lock_vs3", locked, 1'b1);
    chk("fs_count_1", n_fs, 1);
    chk("fs_cyc", fs_cyc, vs_cyc + 1);
    drive_line(H, H, 2);
    chk("first_o_de_cyc", ode_rise_cyc, line_cyc + 1);
    chk("q_empty_first", exp_q.size(), 0);
    frame(V - 1, 1);
    vsync_pulse();
    chk("fs_count_2", n_fs, 2);
    chk("locked_steady", locked, 1'b1);

    // Short line while locked
    drive_line(H - 1, H - 1, 2);
    chk("short_err_h_n", n_err_h, 1);
    chk("short_err_h_cyc", err_h_cyc, fall_cyc + 1);
    chk("short_unlocked", locked, 1'b0);
    chk("short_err_count", err_count, 1);
    chk("q_empty_short", exp_q.size(), 0);
    frame(V - 1, 0);
    vsync_pulse(); frame(V, 0);
    vsync_pulse(); chk("relock_early", locked, 1'b0); frame(V, 0);
    vsync_pulse();
    chk("relock", locked, 1'b1);
    chk("relock_err_v", n_err_v, 0);
    chk("fs_count_3", n_fs, 3);

    // Overlong line while locked
    drive_line(H + 5, H, 2);
    chk("long_err_h_n", n_err_h, 2);
    chk("long_err_h_cyc", err_h_cyc, over_cyc + 1);
    chk("q_empty_long", exp_q.size(), 0);
    chk("long_unlocked", locked, 1'b0);
    chk("long_err_count", err_count, 2);
    frame(V - 1, 0);

    // Short frame in ACQUIRE resets the good-frame count
    vsync_pulse(); frame(V, 0);
    vsync_pulse(); frame(V - 1, 0);
    vsync_pulse();
    chk("short_frame_err_v_n", n_err_v, 1);
    chk("short_frame_err_v_cyc", err_v_cyc, vs_cyc + 1);
    chk("short_frame_unlocked", locked, 1'b0);
    chk("short_frame_state", o_state, ST_ACQUIRE);
    chk("short_frame_err_count", err_count, 2);
    frame(V, 0);
    vsync_pulse();
    chk("good_reset_by_frame", locked, 1'b0);

    // Line error in ACQUIRE also resets the good-frame count
    drive_line(H - 1, 0, 2);
    frame(V - 1, 0);
    chk("acq_line_err_h_n", n_err_h, 3);
    vsync_pulse();
    chk("good_reset_by_line", locked, 1'b0);
    chk("acq_err_count", err_count, 2);
    frame(V, 0); vsync_pulse(); chk("acq_one_good", locked, 1'b0);
    frame(V, 0); vsync_pulse();
    chk("relock_2", locked, 1'b1);
    chk("fs_count_4", n_fs, 4);

    // Last line ends on the same cycle as the frame edge
    frame(V - 1, 1);
    drive_line(H, H, 0);
    vsync_pulse();
    chk("simul_locked", locked, 1'b1);
    chk("simul_err_v_n", n_err_v, 1);
    chk("simul_err_h_n", n_err_h, 3);
    chk("fs_count_5", n_fs, 5);
    chk("q_empty_simul", exp_q.size(), 0);

    // Repeated lock losses saturate err_count
    for (int k = 0; k < 300; k++) begin
      drive_line(H - 1, H - 1, 2);
      vsync_pulse(); frame(V, 0);
      vsync_pulse(); frame(V, 0);
      vsync_pulse();
    end
    chk("sat_err_count", err_count, 255);
    chk("sat_locked", locked, 1'b1);
    chk("sat_err_h_n", n_err_h, 303);
    chk("sat_fs_count", n_fs, 305);

    // Reset in the middle of a locked frame
    drive_line(H, H, 2);
    chk("q_empty_pre_rst", exp_q.size(), 0);
    rst = 1'b1;
    #1;
    chk("midrst_err_count", err_count, 0);
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_state", o_state, ST_UNLOCKED);
    chk("midrst_o_de", o_de, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    vsync_pulse();
    chk("post_rst_unchecked", n_err_v, 1);
    frame(V, 0);
    vsync_pulse();
    chk("post_rst_acq_good", locked, 1'b0);
`ifdef VIN_FRAME_SYNC_STATS_EN
    chk("meas_h", meas_h, H);
    chk("meas_v", meas_v, V);
`endif
    chk("final_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
